// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control.
// Holds the FSM state encoding, ALU operation codes, the ALU usage classes
// passed to the ALU decoder, the supported opcode/funct values and the
// datapath mux select codes. The ALU and datapath decode the same codes.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2,
    ALU_SRL = 3'd3,
    ALU_SLL = 3'd4,
    ALU_OR  = 3'd5,
    ALU_AND = 3'd6,
    ALU_NOR = 3'd7
  } alu_op_e;

  // What the ALU is being used for in the current state
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_BRANCH = 2'd3;

  // Opcodes that take the register-immediate ALU path
  function automatic logic is_itype_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// mc_alu_decoder: purely combinational ALU control decode.
// Ports:
//   opcode    in  6  instruction opcode
//   funct     in  6  instruction funct field (R-type)
//   alu_class in  2  how the ALU is used this state (alu_class_e)
//   alu_ctrl  out 3  ALU operation (alu_op_e)
//   ext_zero  out 1  zero-extend the immediate (andi/ori)
//   shift_sel out 1  R-type shift: shamt on operand A
//   funct_ok  out 1  funct is supported (only meaningful for R-type)
module mc_alu_decoder (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] alu_class,
  output logic [2:0] alu_ctrl,
  output logic       ext_zero,
  output logic       shift_sel,
  output logic       funct_ok
);
  import mc_control_fsm_pkg::*;

  always_comb begin
    alu_ctrl  = ALU_ADD;
    ext_zero  = 1'b0;
    shift_sel = 1'b0;
    funct_ok  = 1'b1;
    case (alu_class)
      CLS_SUB: alu_ctrl = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          // The ALU shifts operand B by operand A, so shamt rides on A
          FN_SLL: begin
            alu_ctrl  = ALU_SLL;
            shift_sel = 1'b1;
          end
          FN_SRL: begin
            alu_ctrl  = ALU_SRL;
            shift_sel = 1'b1;
          end
          default: funct_ok = 1'b0;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: begin
            alu_ctrl = ALU_AND;
            ext_zero = 1'b1;
          end
          OP_ORI: begin
            alu_ctrl = ALU_OR;
            ext_zero = 1'b1;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control (Moore FSM).
// Sequences the shared ALU, memory port, IR, PC and register file through
// FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, traps on unsupported
// opcodes/functs and parks in HALT on HALT_OP.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   opcode, funct        IR fields, stable from DECODE on
//   zero                 ALU zero flag (BRANCH only)
//   mem_ready            memory access completes this cycle
//   pc_en, pc_src        PC load enable and source select
//   iord, mem_read, mem_write  memory address select and requests
//   ir_write             IR load
//   reg_dst, mem_to_reg, reg_write  register file write controls
//   alu_src_a, alu_src_b, ext_zero, alu_ctrl  ALU operand/op controls
//   state                current state (debug)
//   illegal              sticky, set when TRAP is entered
module mc_control_fsm #(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       illegal
);
  import mc_control_fsm_pkg::*;

  state_e     r_state;
  state_e     w_next;
  logic       r_illegal;
  alu_class_e w_class;
  logic [2:0] w_alu_ctrl;
  logic       w_ext_zero;
  logic       w_shift_sel;
  logic       w_funct_ok;

  mc_alu_decoder u_alu_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_class (w_class),
    .alu_ctrl  (w_alu_ctrl),
    .ext_zero  (w_ext_zero),
    .shift_sel (w_shift_sel),
    .funct_ok  (w_funct_ok)
  );

  // ALU class depends on state alone, kept apart from the main decode so
  // the decoder feedback does not form a combinational loop
  always_comb begin
    case (r_state)
      S_EXEC_R: w_class = CLS_RTYPE;
      S_EXEC_I: w_class = CLS_ITYPE;
      S_BRANCH: w_class = CLS_SUB;
      default:  w_class = CLS_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_en      = 1'b0;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    alu_ctrl   = w_alu_ctrl;
    ext_zero   = w_ext_zero;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_BRANCH;
        case (opcode)
          OP_RTYPE:       w_next = S_EXEC_R;
          OP_LW, OP_SW:   w_next = S_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          // A HALT_OP equal to a supported opcode is shadowed by it
          default: begin
            if (is_itype_op(opcode))    w_next = S_EXEC_I;
            else if (opcode == HALT_OP) w_next = S_HALT;
            else                        w_next = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = w_shift_sel ? SRC_A_SHAMT : SRC_A_RS;
        w_next    = w_funct_ok ? S_WB_R : S_TRAP;
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        w_next    = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = (opcode == OP_BEQ) ? zero : !zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_en  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT, S_TRAP: w_next = r_state;
      default: w_next = S_FETCH;
    endcase
    // While reset is held every strobe and select is forced low, so an
    // access in flight is dropped without waiting for a clock edge
    if (!rst_n) begin
      pc_en      = 1'b0;
      pc_src     = PC_SRC_ALU;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RT;
      alu_ctrl   = ALU_ADD;
      ext_zero   = 1'b0;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle pushes the
// hand-derived expected output vector; a negedge monitor pops and compares.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       pcEn;
    logic [1:0] pcSrc;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic       extZero;
    logic [2:0] alu;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;

  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, ext_zero, illegal;
  logic [1:0] pc_src, alu_src_a, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  exp_t  expQ[$];
  string nameQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (memReady),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .alu_ctrl   (alu_ctrl),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Expected-value helpers: a state with every strobe/select at 0
  function automatic exp_t blank(input state_e s, input logic ill);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.ill = ill;
    return e;
  endfunction

  function automatic exp_t fetchExp(input logic rdy);
    exp_t e;
    e         = blank(S_FETCH, 1'b0);
    e.memRead = 1'b1;
    e.srcB    = 2'd1;
    e.irWrite = rdy;
    e.pcEn    = rdy;
    return e;
  endfunction

  function automatic exp_t decodeExp();
    exp_t e;
    e      = blank(S_DECODE, 1'b0);
    e.srcB = 2'd3;
    return e;
  endfunction

  // Drive one cycle of inputs (at posedge+1) and queue its expectation
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy,
                               input exp_t e, input string nm);
    opcode   = op;
    funct    = fn;
    zero     = z;
    memReady = rdy;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    exp_t act;
    act = {state, illegal, pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_ctrl};
    testsRun++;
    if (act !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h (state %0d) required %h (state %0d)",
               nm, act, act.st, e, e.st);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
  end

  task automatic pulseReset(input string nm);
    rst_n = 1'b0;
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b1, blank(S_FETCH, 1'b0), nm);
    rst_n = 1'b1;
  endtask

  task automatic runR(input logic [5:0] fn, input logic [2:0] alu,
                      input logic [1:0] srcA, input string nm);
    exp_t e;
    applyStimulus(6'h00, fn, 1'b0, 1'b1, fetchExp(1'b1), {nm, " FETCH"});
    applyStimulus(6'h00, fn, 1'b0, 1'b1, decodeExp(), {nm, " DECODE"});
    e      = blank(S_EXEC_R, 1'b0);
    e.srcA = srcA;
    e.alu  = alu;
    applyStimulus(6'h00, fn, 1'b0, 1'b1, e, {nm, " EXEC_R"});
    e          = blank(S_WB_R, 1'b0);
    e.regDst   = 1'b1;
    e.regWrite = 1'b1;
    applyStimulus(6'h00, fn, 1'b0, 1'b1, e, {nm, " WB_R"});
  endtask

  task automatic runI(input logic [5:0] op, input logic [2:0] alu,
                      input logic ext, input string nm);
    exp_t e;
    applyStimulus(op, 6'h15, 1'b0, 1'b1, fetchExp(1'b1), {nm, " FETCH"});
    applyStimulus(op, 6'h15, 1'b0, 1'b1, decodeExp(), {nm, " DECODE"});
    e         = blank(S_EXEC_I, 1'b0);
    e.srcA    = 2'd1;
    e.srcB    = 2'd2;
    e.alu     = alu;
    e.extZero = ext;
    applyStimulus(op, 6'h15, 1'b0, 1'b1, e, {nm, " EXEC_I"});
    e          = blank(S_WB_I, 1'b0);
    e.regWrite = 1'b1;
    applyStimulus(op, 6'h15, 1'b0, 1'b1, e, {nm, " WB_I"});
  endtask

  // Zero is held opposite in FETCH/DECODE so only the BRANCH value matters
  task automatic runBranch(input logic [5:0] op, input logic z,
                           input logic pcEn, input string nm);
    exp_t e;
    applyStimulus(op, 6'h00, !z, 1'b1, fetchExp(1'b1), {nm, " FETCH"});
    applyStimulus(op, 6'h00, !z, 1'b1, decodeExp(), {nm, " DECODE"});
    e       = blank(S_BRANCH, 1'b0);
    e.srcA  = 2'd1;
    e.pcSrc = 2'd1;
    e.alu   = 3'd1;
    e.pcEn  = pcEn;
    applyStimulus(op, 6'h00, z, 1'b1, e, {nm, " BRANCH"});
  endtask

  // R-type table: funct, expected alu_ctrl, expected alu_src_a
  logic [5:0] rFn  [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
  logic [2:0] rAlu [10] = '{3'd0,  3'd0,  3'd1,  3'd1,  3'd6,  3'd5,  3'd7,  3'd2,  3'd4,  3'd3};
  logic [1:0] rSrcA[10] = '{2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd1,  2'd2,  2'd2};
  // I-type table: opcode, expected alu_ctrl, expected ext_zero
  logic [5:0] iOp  [5]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
  logic [2:0] iAlu [5]  = '{3'd0,  3'd0,  3'd2,  3'd6,  3'd5};
  logic       iExt [5]  = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

  initial begin
    exp_t e;
    @(posedge clk);
    #1;
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b1, blank(S_FETCH, 1'b0), "reset idle 0");
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b1, blank(S_FETCH, 1'b0), "reset idle 1");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) runR(rFn[i], rAlu[i], rSrcA[i], $sformatf("R fn%0h", rFn[i]));
    for (int i = 0; i < 5; i++)  runI(iOp[i], iAlu[i], iExt[i], $sformatf("I op%0h", iOp[i]));

    // lw with two wait states in MEM_RD: 7 cycles total
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, fetchExp(1'b1), "lw FETCH");
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, decodeExp(), "lw DECODE");
    e = blank(S_ADDR, 1'b0); e.srcA = 2'd1; e.srcB = 2'd2;
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, e, "lw ADDR");
    e = blank(S_MEM_RD, 1'b0); e.iord = 1'b1; e.memRead = 1'b1;
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, e, "lw MEM_RD wait0");
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, e, "lw MEM_RD wait1");
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, e, "lw MEM_RD done");
    e = blank(S_WB_MEM, 1'b0); e.memToReg = 1'b1; e.regWrite = 1'b1;
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, e, "lw WB_MEM");

    // sw with one FETCH wait state
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0, fetchExp(1'b0), "sw FETCH wait");
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1, fetchExp(1'b1), "sw FETCH");
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1, decodeExp(), "sw DECODE");
    e = blank(S_ADDR, 1'b0); e.srcA = 2'd1; e.srcB = 2'd2;
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1, e, "sw ADDR");
    e = blank(S_MEM_WR, 1'b0); e.iord = 1'b1; e.memWrite = 1'b1;
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1, e, "sw MEM_WR");

    runBranch(6'h04, 1'b1, 1'b1, "beq taken");
    runBranch(6'h04, 1'b0, 1'b0, "beq not taken");
    runBranch(6'h05, 1'b1, 1'b0, "bne not taken");
    runBranch(6'h05, 1'b0, 1'b1, "bne taken");

    applyStimulus(6'h02, 6'h00, 1'b0, 1'b1, fetchExp(1'b1), "j FETCH");
    applyStimulus(6'h02, 6'h00, 1'b0, 1'b1, decodeExp(), "j DECODE");
    e = blank(S_JUMP, 1'b0); e.pcSrc = 2'd2; e.pcEn = 1'b1;
    applyStimulus(6'h02, 6'h00, 1'b0, 1'b1, e, "j JUMP");

    // Reset during a FETCH wait, then one clean add
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b0, fetchExp(1'b0), "rst FETCH wait");
    rst_n = 1'b0;
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b1, blank(S_FETCH, 1'b0), "rst mid fetch");
    rst_n = 1'b1;
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b0, fetchExp(1'b0), "post rst FETCH wait");
    runR(6'h20, 3'd0, 2'd1, "post rst add");

    // HALT parks with illegal clear
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b1, fetchExp(1'b1), "halt FETCH");
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b1, decodeExp(), "halt DECODE");
    for (int i = 0; i < 3; i++)
      applyStimulus(6'h3F, 6'h00, 1'b1, 1'b1, blank(S_HALT, 1'b0), "halt park");
    pulseReset("reset from HALT");

    // Unsupported R-type funct traps without a register write
    applyStimulus(6'h00, 6'h18, 1'b0, 1'b1, fetchExp(1'b1), "fn18 FETCH");
    applyStimulus(6'h00, 6'h18, 1'b0, 1'b1, decodeExp(), "fn18 DECODE");
    e = blank(S_EXEC_R, 1'b0); e.srcA = 2'd1;
    applyStimulus(6'h00, 6'h18, 1'b0, 1'b1, e, "fn18 EXEC_R");
    for (int i = 0; i < 3; i++)
      applyStimulus(6'h00, 6'h18, 1'b0, 1'b1, blank(S_TRAP, 1'b1), "fn18 TRAP");
    pulseReset("reset from fn18 TRAP");

    // Unsupported opcode traps; illegal holds for 100 cycles
    applyStimulus(6'h10, 6'h00, 1'b0, 1'b1, fetchExp(1'b1), "op10 FETCH");
    applyStimulus(6'h10, 6'h00, 1'b0, 1'b1, decodeExp(), "op10 DECODE");
    for (int i = 0; i < 100; i++)
      applyStimulus(6'h10, 6'h00, i[1], i[0], blank(S_TRAP, 1'b1), "op10 TRAP hold");
    pulseReset("reset from op10 TRAP");
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b1, fetchExp(1'b1), "after TRAP FETCH");

    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at 200000 ns, required to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
